// File: rtl/ps2_key_pkg.sv
// Shared scan-code constants, decoder state encoding and key_held bit indices for ps2_key_tracker.
// ext_key() holds the E0-prefixed arrow table, used only when PS2_EXT_ARROWS_EN is defined.
package ps2_key_pkg;

  localparam logic [7:0] CODE_E0         = 8'hE0;
  localparam logic [7:0] CODE_F0         = 8'hF0;
  localparam logic [7:0] CODE_UP         = 8'h73;
  localparam logic [7:0] CODE_DOWN       = 8'h72;
  localparam logic [7:0] CODE_LEFT       = 8'h69;
  localparam logic [7:0] CODE_RIGHT      = 8'h7A;
  localparam logic [7:0] CODE_EXT_UP     = 8'h75;
  localparam logic [7:0] CODE_EXT_DOWN   = 8'h72;
  localparam logic [7:0] CODE_EXT_LEFT   = 8'h6B;
  localparam logic [7:0] CODE_EXT_RIGHT  = 8'h74;

  // key_held is {right, left, down, up}
  localparam logic [1:0] KEY_UP    = 2'd0;
  localparam logic [1:0] KEY_DOWN  = 2'd1;
  localparam logic [1:0] KEY_LEFT  = 2'd2;
  localparam logic [1:0] KEY_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } key_hit_t;

  function automatic key_hit_t base_key(input logic [7:0] code);
    key_hit_t h;
    h.valid = 1'b1;
    h.idx   = KEY_UP;
    case (code)
      CODE_UP:    h.idx = KEY_UP;
      CODE_DOWN:  h.idx = KEY_DOWN;
      CODE_LEFT:  h.idx = KEY_LEFT;
      CODE_RIGHT: h.idx = KEY_RIGHT;
      default:    h.valid = 1'b0;
    endcase
    return h;
  endfunction

  function automatic key_hit_t ext_key(input logic [7:0] code);
    key_hit_t h;
    h.valid = 1'b1;
    h.idx   = KEY_UP;
    case (code)
      CODE_EXT_UP:    h.idx = KEY_UP;
      CODE_EXT_DOWN:  h.idx = KEY_DOWN;
      CODE_EXT_LEFT:  h.idx = KEY_LEFT;
      CODE_EXT_RIGHT: h.idx = KEY_RIGHT;
      default:        h.valid = 1'b0;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/ps2_byte_timeout.sv
// Inter-byte timeout: counts while a prefix is pending, saturates at TIMEOUT_CYCLES-1 and flags expiry.
module ps2_byte_timeout #(
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign expired = run && (cnt == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!run || clear) begin
      cnt <= '0;
    end else if (!expired) begin
      // NOTE: state registers use <= so every flop samples pre-edge values; = here would create order-dependent races.
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 make/break decoder tracking the four arrow keys and deriving accel/turn commands.
// Define PS2_EXT_ARROWS_EN to also map the E0-prefixed arrow keys onto the same held bits.
module ps2_key_tracker
  import ps2_key_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic [3:0] key_held,
  output logic [1:0] accel,
  output logic [1:0] turn,
  output logic       key_event
);

  state_t     state, state_nxt;
  logic [3:0] held_nxt;
  logic       expired;
  logic       ext_state;
  logic       make_state;
  key_hit_t   hit;

  ps2_byte_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clock   (CLOCK_50),
    .reset   (reset),
    .run     (state != ST_IDLE),
    .clear   (received_data_en),
    .expired (expired)
  );

  assign ext_state  = (state == ST_EXT) || (state == ST_EXT_BRK);
  assign make_state = (state == ST_IDLE) || (state == ST_EXT);

  // Extended bytes are looked up only in the extended table so they never alias base codes.
`ifdef PS2_EXT_ARROWS_EN
  assign hit = ext_state ? ext_key(received_data) : base_key(received_data);
`else
  assign hit = ext_state ? key_hit_t'('0) : base_key(received_data);
`endif

  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
    state_nxt = state;
    held_nxt  = key_held;
    if (received_data_en) begin
      if (received_data == CODE_E0 && (state == ST_IDLE || state == ST_EXT)) begin
        state_nxt = ST_EXT;
      end else if (received_data == CODE_F0 && (state == ST_IDLE || state == ST_BRK)) begin
        state_nxt = ST_BRK;
      end else if (received_data == CODE_F0 && state == ST_EXT) begin
        state_nxt = ST_EXT_BRK;
      end else begin
        state_nxt = ST_IDLE;
        if (hit.valid) held_nxt[hit.idx] = make_state;
      end
    end else if (expired) begin
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      key_held  <= '0;
      accel     <= '0;
      turn      <= '0;
      key_event <= 1'b0;
    end else begin
      state     <= state_nxt;
      key_held  <= held_nxt;
      accel     <= {held_nxt[KEY_DOWN] & ~held_nxt[KEY_UP], held_nxt[KEY_UP] & ~held_nxt[KEY_DOWN]};
      turn      <= {held_nxt[KEY_RIGHT] & ~held_nxt[KEY_LEFT], held_nxt[KEY_LEFT] & ~held_nxt[KEY_RIGHT]};
      key_event <= (held_nxt != key_held);
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: directed scenarios with literal expectations plus
// randomized byte streams checked every cycle against a prefix-flag/held-array reference model.
module tb_ps2_key_tracker;

  localparam int T = 16;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] received_data = 8'h00;
  logic       received_data_en = 1'b0;
  logic [3:0] key_held;
  logic [1:0] accel;
  logic [1:0] turn;
  logic       key_event;

  ps2_key_tracker #(.TIMEOUT_CYCLES(T)) dut (
    .CLOCK_50         (CLOCK_50),
    .reset            (reset),
    .received_data    (received_data),
    .received_data_en (received_data_en),
    .key_held         (key_held),
    .accel            (accel),
    .turn             (turn),
    .key_event        (key_event)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_errors = 0;
  int ev_count = 0;
  bit cmp_en   = 1'b0;

  // Reference model: pending-prefix flags, the time of the last byte, and the held-key array.
  bit         m_ext = 1'b0;
  bit         m_brk = 1'b0;
  int         m_cyc = 0;
  int         m_last = 0;
  logic [3:0] m_held = 4'b0000;
  logic       m_event = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_key(input logic [7:0] code, input bit ext);
    if (!ext) begin
      case (code)
        8'h73: return 0;
        8'h72: return 1;
        8'h69: return 2;
        8'h7A: return 3;
        default: return -1;
      endcase
    end
`ifdef PS2_EXT_ARROWS_EN
    case (code)
      8'h75: return 0;
      8'h72: return 1;
      8'h6B: return 2;
      8'h74: return 3;
      default: return -1;
    endcase
`else
    return -1;
`endif
  endfunction

  function automatic logic [1:0] pair_cmd(input logic pos, input logic neg);
    if (pos && !neg) return 2'b01;
    if (neg && !pos) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_held = 4'b0000; m_event = 0;
  endtask

  task automatic model_update(input logic en, input logic [7:0] d);
    int idx;
    logic newv;
    m_cyc++;
    m_event = 0;
    if ((m_ext || m_brk) && (m_cyc - m_last > T)) begin
      m_ext = 0; m_brk = 0;
    end
    if (en) begin
      m_last = m_cyc;
      if (d == 8'hE0 && !m_brk) begin
        m_ext = 1;
      end else if (d == 8'hF0 && !m_brk) begin
        m_brk = 1;
      end else if (d == 8'hF0 && m_brk && !m_ext) begin
        m_brk = 1;
      end else begin
        idx = model_key(d, m_ext);
        if (idx >= 0) begin
          newv = !m_brk;
          if (m_held[idx] != newv) begin
            m_held[idx] = newv;
            m_event = 1;
          end
        end
        m_ext = 0; m_brk = 0;
      end
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (cmp_en) begin
      check("key_held", 8'(key_held), 8'(m_held));
      check("accel", 8'(accel), 8'(pair_cmd(m_held[0], m_held[1])));
      check("turn", 8'(turn), 8'(pair_cmd(m_held[2], m_held[3])));
      check("key_event", 8'(key_event), 8'(m_event));
      if (key_event === 1'b1) ev_count++;
    end
  end

  task automatic step(input logic en, input logic [7:0] d);
    received_data_en = en;
    received_data    = d;
    @(posedge CLOCK_50);
    #1;
    model_update(en, d);
    received_data_en = 1'b0;
    received_data    = $urandom_range(0, 255);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    received_data_en = 1'b0;
    model_reset();
    repeat (cycles) @(posedge CLOCK_50);
    #1;
    reset = 1'b1;
  endtask

  logic [7:0] pool [14] = '{8'h73, 8'h72, 8'h69, 8'h7A, 8'h75, 8'h6B, 8'h74,
                            8'hE0, 8'hF0, 8'hAA, 8'hFA, 8'h12, 8'hE0, 8'hF0};

  initial begin
    #(3_000_000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ev0;
    int r;
    cmp_en = 1'b1;
    do_reset(2);
    check("reset_held", 8'(key_held), 8'h0);
    check("reset_accel", 8'(accel), 8'h0);
    check("reset_turn", 8'(turn), 8'h0);
    check("reset_event", 8'(key_event), 8'h0);

    // 73 then F0 73
    ev0 = ev_count;
    step(1, 8'h73);
    check("up_make_held", 8'(key_held), 8'h01);
    check("up_make_accel", 8'(accel), 8'h01);
    step(1, 8'hF0); step(1, 8'h73); step(0, 8'h00);
    check("up_break_held", 8'(key_held), 8'h00);
    check("up_break_accel", 8'(accel), 8'h00);
    check("up_events", 8'(ev_count - ev0), 8'd2);

    // up and down both held, then release up
    step(1, 8'h73); step(1, 8'h72);
    check("updown_accel", 8'(accel), 8'h00);
    step(1, 8'hF0); step(1, 8'h73);
    check("down_only_accel", 8'(accel), 8'h02);

    // extended left, and base 72 vs E0 72 aliasing
    do_reset(1);
    step(1, 8'hE0); step(1, 8'h6B);
`ifdef PS2_EXT_ARROWS_EN
    check("ext_left_turn", 8'(turn), 8'h01);
    check("ext_left_held", 8'(key_held), 8'h04);
`else
    check("ext_left_turn", 8'(turn), 8'h00);
    check("ext_left_held", 8'(key_held), 8'h00);
`endif
    do_reset(1);
    step(1, 8'hE0); step(1, 8'h72);
`ifdef PS2_EXT_ARROWS_EN
    check("ext_down_held", 8'(key_held), 8'h02);
`else
    check("ext_down_held", 8'(key_held), 8'h00);
`endif
    step(1, 8'h72);
    check("base_down_held", 8'(key_held), 8'h02);

    // F0 prefix still alive at exactly T idle-gap cycles: 69 is a (no-op) break
    do_reset(1);
    step(1, 8'hF0);
    repeat (T - 1) step(0, 8'h00);
    step(1, 8'h69);
    check("timeout_edge_held", 8'(key_held), 8'h00);
    // F0 then T idle clocks: prefix expired, 69 is a make
    step(1, 8'hF0);
    repeat (T) step(0, 8'h00);
    step(1, 8'h69);
    check("timeout_make_held", 8'(key_held), 8'h04);
    check("timeout_make_turn", 8'(turn), 8'h01);

    // typematic repeat of right
    do_reset(1);
    ev0 = ev_count;
    repeat (5) step(1, 8'h7A);
    step(0, 8'h00);
    check("repeat_held", 8'(key_held), 8'h08);
    check("repeat_events", 8'(ev_count - ev0), 8'd1);

    // reset mid E0 F0 sequence
    step(1, 8'h73); step(1, 8'hE0); step(1, 8'hF0);
    reset = 1'b0;
    model_reset();
    #1;
    check("async_rst_held", 8'(key_held), 8'h00);
    check("async_rst_accel", 8'(accel), 8'h00);
    check("async_rst_turn", 8'(turn), 8'h00);
    repeat (2) @(posedge CLOCK_50);
    #1;
    reset = 1'b1;
    step(1, 8'h74);
    check("post_rst_74_held", 8'(key_held), 8'h00);
    step(1, 8'h73);
    check("post_rst_73_held", 8'(key_held), 8'h01);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset($urandom_range(1, 3));
      end else if (r < 6) begin
        repeat (T - 2 + $urandom_range(0, 4)) step(0, 8'h00);
      end else if (r < 50) begin
        step(0, 8'h00);
      end else if (r < 56) begin
        step(1, 8'($urandom_range(0, 255)));
      end else begin
        step(1, pool[$urandom_range(0, 13)]);
      end
    end

    step(0, 8'h00);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
